// File: rtl/mem_responder_pkg.sv
// Shared types and constants for the mem_responder block.
package mem_responder_pkg;

    localparam int WSTRB_W  = 4;
    localparam int WAIT_MAX = 15;
    localparam logic [31:0] RDATA_ZERO = 32'h0000_0000;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
    typedef enum logic {PORT_I, PORT_D} port_t;

    // Misaligned or beyond the end of the array: the access is suppressed.
    function automatic logic is_fault(input logic [31:0] addr, input int unsigned depth);
        return (addr[1:0] != 2'b00) || (addr >= 32'(depth * 4));
    endfunction

endpackage

// File: rtl/mem_array.sv
// DEPTH x 32 word storage: synchronous byte-strobed write, registered read.
module mem_array
    import mem_responder_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               en,
    input  logic               we,
    input  logic [AW-1:0]      idx,
    input  logic [31:0]        wdata,
    input  logic [WSTRB_W-1:0] wstrb,
    output logic [31:0]        rdata
);

    logic [31:0] mem [DEPTH];

    // Contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int b = 0; b < WSTRB_W; b++) begin
                    if (wstrb[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end else begin
                rdata <= mem[idx];
            end
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Two-port (fetch/data) memory responder with WAIT programmable wait states.
// Define MEM_RESPONDER_WSTRB_EN to honour d_wstrb; otherwise writes are full-word.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int WAIT  = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_req,
    input  logic [31:0]        i_addr,
    output logic               i_ready,
    output logic               i_rvalid,
    output logic [31:0]        i_rdata,
    output logic               i_err,
    input  logic               d_req,
    input  logic               d_we,
    input  logic [31:0]        d_addr,
    input  logic [31:0]        d_wdata,
    input  logic [WSTRB_W-1:0] d_wstrb,
    output logic               d_ready,
    output logic               d_rvalid,
    output logic [31:0]        d_rdata,
    output logic               d_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(WAIT_MAX + 1);

    state_t             state, state_next;
    logic [CW-1:0]      wcnt, wcnt_next;
    port_t              last_grant, grant, port_q;
    logic               accept, ready;
    logic [31:0]        addr_q, wdata_q;
    logic               we_q;
    logic [WSTRB_W-1:0] wstrb_q;

    logic [31:0]        acc_addr, acc_wdata, mem_rdata;
    logic               acc_we, mem_en, resp_fault;
    logic [WSTRB_W-1:0] acc_wstrb;

    always_comb begin
        state_next = state;
        wcnt_next  = wcnt;
        accept     = 1'b0;
        if (i_req && d_req) grant = (last_grant == PORT_I) ? PORT_D : PORT_I;
        else if (d_req)     grant = PORT_D;
        else                grant = PORT_I;
        case (state)
            S_IDLE: begin
                if (ready && (i_req || d_req)) begin
                    accept     = 1'b1;
                    wcnt_next  = CW'(WAIT);
                    state_next = (WAIT == 0) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                wcnt_next = wcnt - CW'(1);
                if (wcnt <= CW'(1)) state_next = S_RESP;
            end
            S_RESP:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // The array is accessed on the edge entering RESP; with WAIT=0 that is the
    // accept edge itself, so the request is taken straight from the inputs.
    assign acc_addr  = (state == S_IDLE) ? ((grant == PORT_D) ? d_addr : i_addr) : addr_q;
    assign acc_we    = (state == S_IDLE) ? ((grant == PORT_D) && d_we) : we_q;
    assign acc_wdata = (state == S_IDLE) ? d_wdata : wdata_q;
`ifdef MEM_RESPONDER_WSTRB_EN
    assign acc_wstrb = (state == S_IDLE) ? d_wstrb : wstrb_q;
`else
    assign acc_wstrb = {WSTRB_W{1'b1}};
    logic unused_wstrb;
    assign unused_wstrb = ^wstrb_q;
`endif
    assign mem_en     = (state_next == S_RESP) && (state != S_RESP) && !is_fault(acc_addr, DEPTH);
    assign resp_fault = is_fault(addr_q, DEPTH);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            wcnt       <= '0;
            last_grant <= PORT_I;
            ready      <= 1'b0;
            port_q     <= PORT_I;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
        end else begin
            state <= state_next;
            wcnt  <= wcnt_next;
            ready <= (state_next == S_IDLE);
            if (accept) begin
                last_grant <= grant;
                port_q     <= grant;
                addr_q     <= acc_addr;
                we_q       <= acc_we;
                wdata_q    <= d_wdata;
                wstrb_q    <= d_wstrb;
            end
        end
    end

    assign i_ready = ready;
    assign d_ready = ready;

    // Response registers: rdata holds between strobes, rvalid/err are pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            i_rvalid <= 1'b0;
            d_rvalid <= 1'b0;
            i_err    <= 1'b0;
            d_err    <= 1'b0;
            i_rdata  <= RDATA_ZERO;
            d_rdata  <= RDATA_ZERO;
        end else begin
            i_rvalid <= 1'b0;
            d_rvalid <= 1'b0;
            i_err    <= 1'b0;
            d_err    <= 1'b0;
            if (state == S_RESP) begin
                if (port_q == PORT_I) begin
                    i_rvalid <= 1'b1;
                    i_err    <= resp_fault;
                    i_rdata  <= resp_fault ? RDATA_ZERO : mem_rdata;
                end else begin
                    d_rvalid <= 1'b1;
                    d_err    <= resp_fault;
                    d_rdata  <= (resp_fault || we_q) ? RDATA_ZERO : mem_rdata;
                end
            end
        end
    end

    mem_array #(.DEPTH(DEPTH), .AW(AW)) u_array (
        .clk   (clk),
        .en    (mem_en),
        .we    (acc_we),
        .idx   (acc_addr[AW+1:2]),
        .wdata (acc_wdata),
        .wstrb (acc_wstrb),
        .rdata (mem_rdata)
    );

endmodule

// File: doc/mem_responder.md
# mem_responder

Memory-side responder for the RISC-V core's instruction-fetch and data-access ports. It holds one unified word array and serves two requesters, instruction read-only and data read/write. Each requester uses a valid/ready request handshake, and the block answers after a programmable number of wait states. It sits between the core's memory interface and the testbench or top level. It replaces the combinational imem/dmem models so that the core and its future stall logic are exercised against non-zero-latency memory.

## Interface
Parameters:
- DEPTH, 64: number of 32-bit words; power of two, 4..4096
- WAIT, 1: wait states per access, 0..15

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- i_req  in  1  instruction fetch request
- i_addr  in  32  fetch byte address
- i_ready  out  1  request accepted when i_req & i_ready at a rising edge
- i_rvalid  out  1  one-cycle response strobe
- i_rdata  out  32  fetched word, valid while i_rvalid
- i_err  out  1  fault flag, valid while i_rvalid
- d_req  in  1  data request
- d_we  in  1  1 = write, 0 = read
- d_addr  in  32  data byte address
- d_wdata  in  32  write data
- d_wstrb  in  4  byte enables; bit n covers d_wdata[8n+7:8n]
- d_ready  out  1  data request accepted when d_req & d_ready at a rising edge
- d_rvalid  out  1  one-cycle response/ack strobe
- d_rdata  out  32  read word (0 for writes), valid while d_rvalid
- d_err  out  1  fault flag, valid while d_rvalid

## Operation
- FSM states:
  - IDLE: i_ready = d_ready = 1.
  - WAIT: counter runs, both readies 0.
  - RESP: one rvalid cycle, both readies 0, then back to IDLE.
- Arbitration in IDLE:
  - Single request: that request is granted.
  - Both requesting: round-robin against last_grant. After reset last_grant = I, so data wins the first tie.
  - Only the granted port's readies matter. The losing port's request is not accepted; its requester holds the request.
- Acceptance captures port id, addr, we, wdata and wstrb into registers. Inputs may change afterwards.
- Acceptance loads wcnt = WAIT. WAIT state decrements wcnt and leaves for RESP when wcnt reaches 0. WAIT=0 goes directly IDLE -> RESP.
- Access is performed at the edge entering RESP:
  - Word index = addr[log2(DEPTH)+1:2].
  - Read: the word is registered into the granted port's rdata.
  - Write: strobed bytes are updated; d_rdata = 0.
- Fault cases, either of which causes no array access, err = 1 with rvalid, and rdata = 0:
  - addr[1:0] != 0
  - addr >= 4*DEPTH
- A write with wstrb = 0 is legal: ack with no change.
- The non-granted port's rvalid/err stay 0. rdata on both ports holds its last value outside rvalid.
- Array contents are not reset (X until written).

## Timing
- Request accepted at edge k -> rvalid high in the cycle following edge k+1+WAIT. Occupancy is WAIT+2 cycles per access; the next request can be accepted at edge k+2+WAIT.
- Reset values:
  - i_ready = d_ready = 0
  - rvalid = err = 0, rdata = 0
  - state IDLE, wcnt 0, last_grant I
- Readies are registered. They rise at the first rising edge after reset deasserts.
- Reset asserted mid-transaction: the transaction is dropped with no response. A pending write is not performed; a write already committed at RESP entry stays.
- The array is written only at RESP entry, never during reset.

## Configuration
- MEM_RESPONDER_WSTRB_EN:
  - Defined: d_wstrb honoured per byte.
  - Undefined: d_wstrb ignored and every write updates all 4 bytes.
  - Port list identical either way.

## Structure
- mem_responder_pkg holds:
  - state enum {IDLE, WAIT, RESP}
  - port-id enum {PORT_I, PORT_D}
  - WSTRB_W = 4
  - WAIT_MAX = 15
  - rdata-zero constant
- Sub-module mem_array: DEPTH x 32 storage, synchronous strobed write, registered read. It holds all storage; the FSM and arbiter stay in mem_responder.

## Test plan
- Reset, then d write addr 0x10 data 0xDEADBEEF strb 0xF, then i read 0x10 -> i_rvalid with 0xDEADBEEF, exactly WAIT+1 cycles after accept.
- Simultaneous i_req/d_req held for 4 transactions -> grant order D, I, D, I; each rvalid pulse is exactly one cycle.
- Write 0x11223344 to 0x0, then write 0xAABBCCDD strb 0b0101, then read -> 0x11BB33DD with the macro, 0xAABBCCDD without.
- d read 0x2, then d read 0x100 with DEPTH=64 -> d_err=1, d_rdata=0 for each; array unchanged.
- WAIT=0 and WAIT=15 builds: back-to-back reads -> accept-to-rvalid spacing of 1 and 16 cycles; accept-to-accept spacing of 2 and 17.
- Assert reset during WAIT of a write to 0x8 -> no d_rvalid; readies 0 during reset and 1 one edge after release; a read of 0x8 returns the pre-reset contents.
